fa_serial_adder: RTL and testbench

//  Bit-serial N-bit adder controller wrapped around the transistor-level 1-bit FA cell.

---
 rtl/fa_ser_pkg.sv | 13 +
 rtl/fa_ser_shreg.sv | 43 ++++
 rtl/fa_serial_adder.sv | 195 +++++++++++++++++++
 tb/tb_fa_serial_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fa_ser_pkg.sv
// Shared types and defaults for the bit-serial full-adder controller.
package fa_ser_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int WIDTH_DEF  = 8;
   localparam int SETTLE_DEF = 1;

endpackage

// File: rtl/fa_ser_shreg.sv
// WIDTH-bit register with synchronous clear, parallel load and right shift
// taking a serial bit in at the MSB.
module fa_ser_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Clear beats load beats shift.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = {WIDTH{1'b0}};
      end else if (load) begin
         q_d = load_val;
      end else if (shift) begin
         q_d = {ser_in, q_q[WIDTH-1:1]};
      end else begin
         q_d = q_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= {WIDTH{1'b0}};
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/fa_serial_adder.sv
// Bit-serial adder controller: drives an external 1-bit full-adder cell LSB-first
// and assembles its Sum/C_out into a registered WIDTH-bit result with carry out.
module fa_serial_adder
   import fa_ser_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout
);

   localparam int BW = $clog2(WIDTH);
   localparam int SW = $clog2(SETTLE + 1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   state_e           state_q;
   state_e           state_d;
   logic             in_ready_q;
   logic             in_ready_d;
   logic             out_valid_q;
   logic             out_valid_d;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             cout_q;
   logic             cout_d;
   logic             carry_q;
   logic             carry_d;
   logic [BW-1:0]    bit_cnt_q;
   logic [BW-1:0]    bit_cnt_d;
   logic [SW-1:0]    settle_cnt_q;
   logic [SW-1:0]    settle_cnt_d;

   logic             op_load;
   logic             op_clr;
   logic             sr_shift;
   logic [WIDTH-1:0] opa_sr;
   logic [WIDTH-1:0] opb_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_next;
   logic             sr_bits_unused;

   // Operand registers are cleared when idle so their LSBs hold the FA drives at 0.
   fa_ser_shreg #(.WIDTH(WIDTH)) u_opa_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (op_clr),
      .load     (op_load),
      .shift    (sr_shift),
      .load_val (op_a),
      .ser_in   (1'b0),
      .q        (opa_sr)
   );

   fa_ser_shreg #(.WIDTH(WIDTH)) u_opb_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (op_clr),
      .load     (op_load),
      .shift    (sr_shift),
      .load_val (op_b),
      .ser_in   (1'b0),
      .q        (opb_sr)
   );

   fa_ser_shreg #(.WIDTH(WIDTH)) u_sum_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (1'b0),
      .load     (op_load),
      .shift    (sr_shift),
      .load_val ({WIDTH{1'b0}}),
      .ser_in   (fa_sum),
      .q        (sum_sr)
   );

   assign sum_next       = {fa_sum, sum_sr[WIDTH-1:1]};
   assign sr_bits_unused = ^{opa_sr[WIDTH-1:1], opb_sr[WIDTH-1:1], sum_sr[0]};

   // Next-state, handshake and sampling control.
   always_comb begin
      state_d      = state_q;
      in_ready_d   = in_ready_q;
      out_valid_d  = out_valid_q;
      sum_d        = sum_q;
      cout_d       = cout_q;
      carry_d      = carry_q;
      bit_cnt_d    = bit_cnt_q;
      settle_cnt_d = settle_cnt_q;
      op_load      = 1'b0;
      op_clr       = 1'b0;
      sr_shift     = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               op_load      = 1'b1;
               carry_d      = c_in;
               bit_cnt_d    = {BW{1'b0}};
               settle_cnt_d = {SW{1'b0}};
               in_ready_d   = 1'b0;
               state_d      = RUN;
            end else begin
               carry_d = 1'b0;
            end
         end
         RUN: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               sr_shift     = 1'b1;
               settle_cnt_d = {SW{1'b0}};
               if (bit_cnt_q == BIT_LAST) begin
                  // Last bit: publish result and park the FA drives at 0.
                  op_clr      = 1'b1;
                  sum_d       = sum_next;
                  cout_d      = fa_cout;
                  carry_d     = 1'b0;
                  bit_cnt_d   = {BW{1'b0}};
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  carry_d   = fa_cout;
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               settle_cnt_d = settle_cnt_q + SW'(1);
            end
         end
         DONE: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            op_clr       = 1'b1;
            carry_d      = 1'b0;
            bit_cnt_d    = {BW{1'b0}};
            settle_cnt_d = {SW{1'b0}};
            out_valid_d  = 1'b0;
            in_ready_d   = 1'b1;
            state_d      = IDLE;
         end
      endcase
   end

   // State, counters, carry and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         sum_q        <= {WIDTH{1'b0}};
         cout_q       <= 1'b0;
         carry_q      <= 1'b0;
         bit_cnt_q    <= {BW{1'b0}};
         settle_cnt_q <= {SW{1'b0}};
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         sum_q        <= sum_d;
         cout_q       <= cout_d;
         carry_q      <= carry_d;
         bit_cnt_q    <= bit_cnt_d;
         settle_cnt_q <= settle_cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign fa_a      = opa_sr[0];
   assign fa_b      = opb_sr[0];
   assign fa_cin    = carry_q;

endmodule

// File: tb/tb_fa_serial_adder.sv
// Self-checking bench for fa_serial_adder with a behavioural FA cell; one instance
// at SETTLE=1 and one at SETTLE=3.
module tb_fa_serial_adder;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic         rst_n, in_valid, in_ready, c_in, out_valid, out_ready, cout;
   logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
   logic [W-1:0] op_a, op_b, sum;

   logic         s3_rst_n, s3_in_valid, s3_in_ready, s3_c_in, s3_out_valid, s3_out_ready, s3_cout;
   logic         s3_fa_a, s3_fa_b, s3_fa_cin, s3_fa_sum, s3_fa_cout;
   logic [W-1:0] s3_op_a, s3_op_b, s3_sum;

   logic [W:0]   exp_q[$];
   logic [W:0]   exp3_q[$];
   logic [W:0]   e3;
   logic [W-1:0] a5, b5, ra, rb;
   logic         rc;
   int           lat;

   assign fa_sum     = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout    = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
   assign s3_fa_sum  = s3_fa_a ^ s3_fa_b ^ s3_fa_cin;
   assign s3_fa_cout = (s3_fa_a & s3_fa_b) | (s3_fa_a & s3_fa_cin) | (s3_fa_b & s3_fa_cin);

   fa_serial_adder #(.WIDTH(W), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
      .fa_sum(fa_sum), .fa_cout(fa_cout)
   );

   fa_serial_adder #(.WIDTH(W), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(s3_rst_n), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
      .op_a(s3_op_a), .op_b(s3_op_b), .c_in(s3_c_in), .out_valid(s3_out_valid),
      .out_ready(s3_out_ready), .sum(s3_sum), .cout(s3_cout), .fa_a(s3_fa_a), .fa_b(s3_fa_b),
      .fa_cin(s3_fa_cin), .fa_sum(s3_fa_sum), .fa_cout(s3_fa_cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      int n = 0;
      op_a = a; op_b = b; c_in = ci; in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int l);
      l = 0;
      while (out_valid !== 1'b1 && l < 400) begin
         @(negedge clk);
         l++;
      end
      chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic take(input string tag, input int stall);
      logic [W:0] e;
      for (int i = 0; i < stall; i++) begin
         out_ready = 1'b0;
         @(negedge clk);
      end
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 'x;
      chk(tag, {23'd0, cout, sum}, {23'd0, e});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0;
      s3_rst_n = 1'b0; s3_in_valid = 1'b0; s3_out_ready = 1'b0;
      s3_op_a = '0; s3_op_b = '0; s3_c_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; s3_rst_n = 1'b1;
      @(negedge clk);

      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
      chk("rst3_in_ready", {31'd0, s3_in_ready}, 32'd1);

      // Basic add and latency.
      accept(8'h0F, 8'h01, 1'b0);
      chk("t1_busy", {31'd0, in_ready}, 32'd0);
      wait_out(lat);
      chk("t1_latency", lat, 32'd8);
      take("t1_result", 0);

      // Overflow wrap.
      accept(8'hFF, 8'h01, 1'b0);
      wait_out(lat);
      take("t2_wrap", 0);
      accept(8'hFF, 8'hFF, 1'b1);
      wait_out(lat);
      take("t2_max", 0);

      // Back-pressure in DONE with in_valid pulses ignored.
      accept(8'h33, 8'h44, 1'b0);
      wait_out(lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         op_a = 8'(i * 17 + 3);
         op_b = 8'(i * 29 + 1);
         chk("t3_sum_stable", {24'd0, sum}, 32'h77);
         chk("t3_cout_stable", {31'd0, cout}, 32'd0);
         chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
         chk("t3_valid_held", {31'd0, out_valid}, 32'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      take("t3_result", 0);
      accept(8'h01, 8'h02, 1'b0);
      wait_out(lat);
      take("t3_after", 0);

      // Reset in the middle of RUN.
      accept(8'hAB, 8'hCD, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_sum", {24'd0, sum}, 32'd0);
      chk("t4_cout", {31'd0, cout}, 32'd0);
      chk("t4_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("t4_stray_ready", {30'd0, out_valid, in_ready}, 32'd1);
      accept(8'h12, 8'h34, 1'b0);
      wait_out(lat);
      take("t4_result", 0);

      // SETTLE=3 instance: each bit held three cycles, latency 24.
      a5 = 8'hA5; b5 = 8'h5A;
      s3_op_a = a5; s3_op_b = b5; s3_c_in = 1'b1; s3_in_valid = 1'b1;
      chk("t5_ready", {31'd0, s3_in_ready}, 32'd1);
      exp3_q.push_back({1'b0, a5} + {1'b0, b5} + 9'd1);
      @(negedge clk);
      s3_in_valid = 1'b0;
      for (int k = 0; k < 24; k++) begin
         chk("t5_fa_a", {31'd0, s3_fa_a}, {31'd0, a5[k / 3]});
         chk("t5_fa_b", {31'd0, s3_fa_b}, {31'd0, b5[k / 3]});
         if (k == 23) chk("t5_not_early", {31'd0, s3_out_valid}, 32'd0);
         @(negedge clk);
      end
      chk("t5_latency", {31'd0, s3_out_valid}, 32'd1);
      e3 = exp3_q.pop_front();
      chk("t5_result", {23'd0, s3_cout, s3_sum}, {23'd0, e3});
      s3_out_ready = 1'b1;
      @(negedge clk);
      s3_out_ready = 1'b0;
      chk("t5_valid_drop", {31'd0, s3_out_valid}, 32'd0);

      // Random operations with stalls on both sides.
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         accept(ra, rb, rc);
         wait_out(lat);
         chk("t6_latency", lat, 32'd8);
         take("t6_result", int'($urandom_range(0, 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
